// File: rtl/shift_loopback_ctrl.sv
// shift_loopback_ctrl
// Sends a parallel word LSB-first into an external N-stage shift register,
// then reads N bits back from the far end of that register. It compares the
// returned word against the sent one and reports the result through a
// valid/ready handshake. A saturating counter tracks how many frames came
// back corrupted.
module shift_loopback_ctrl #(
    parameter int N     = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sh_in,
    input  logic             sh_out,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_IN,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [N-1:0]   tx;
    logic [N-1:0]   rx;
    logic [N-1:0]   rx_next;
    logic           rx_bad;

    // Received word with the bit currently on sh_out merged in, plus its compare result
    always_comb begin
        rx_next      = rx;
        rx_next[cnt] = sh_out;
        rx_bad       = (rx_next != tx);
        cnt_inc      = cnt + CW'(1);
    end

    assign busy = (state != IDLE);

    // Frame controller: accept, serialise out, sample back, present result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tx        <= '0;
            rx        <= '0;
            out_data  <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            sh_in     <= 1'b0;
            err_cnt   <= '0;
            in_ready  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            sh_in     <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        tx       <= in_data;
                        cnt      <= '0;
                        sh_in    <= in_data[0];
                        in_ready <= 1'b0;
                        state    <= SHIFT_IN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT_IN: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        sh_in <= 1'b0;
                        state <= SHIFT_OUT;
                    end else begin
                        cnt   <= cnt_inc;
                        sh_in <= tx[cnt_inc];
                    end
                end
                SHIFT_OUT: begin
                    rx <= rx_next;
                    if (cnt == LAST) begin
                        out_data  <= rx_next;
                        err       <= rx_bad;
                        out_valid <= 1'b1;
                        if (rx_bad && (err_cnt != {CNT_W{1'b1}}))
                            err_cnt <= err_cnt + CNT_W'(1);
                        state     <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_loopback_ctrl.sv
// tb_shift_loopback_ctrl
// Drives shift_loopback_ctrl with a 10-stage shift register model on its
// serial port. The sh_out source can be switched to stuck-at-0 or stuck-at-1.
// The error counter is narrowed to 4 bits so that saturation is reachable.
module tb_shift_loopback_ctrl;

    localparam int N     = 10;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sh_in;
    logic             sh_out;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    logic [N-1:0]     sr;
    int               mode;
    int               checks;
    int               failures;
    int               model_cnt;
    logic [N-1:0]     last_exp;

    shift_loopback_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sh_in     (sh_in),
        .sh_out    (sh_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External N-stage shift register fed by sh_in
    initial sr = '0;
    always @(posedge clk) sr <= {sr[N-2:0], sh_in};

    // Serial return path: 0 = real loopback, 1 = stuck at 0, 2 = stuck at 1
    assign sh_out = (mode == 0) ? sr[N-1] : ((mode == 1) ? 1'b0 : 1'b1);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then hand one word over; returns on the negedge after acceptance
    task automatic startFrame(input logic [N-1:0] word);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ready_before_accept", in_ready, 1);
        in_data  = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = N'($urandom);
        checkOutput("busy_after_accept", busy, 1);
    endtask

    // Follow the frame to DONE, checking the serial stream, latency and result against the model
    task automatic waitResult(input logic [N-1:0] word);
        int lat;
        logic [N-1:0] exp_data;
        logic exp_err;
        exp_data = (mode == 0) ? word : ((mode == 1) ? '0 : '1);
        exp_err  = (exp_data != word);
        if (exp_err && model_cnt < SAT) model_cnt++;
        lat = 0;
        while (!out_valid && lat < 100) begin
            checkOutput("sh_in_stream", sh_in, (lat < N) ? word[lat] : 1'b0);
            @(negedge clk);
            lat++;
        end
        checkOutput("out_valid_rise", out_valid, 1);
        checkOutput("latency", lat, 2 * N);
        checkOutput("out_data", out_data, exp_data);
        checkOutput("err", err, exp_err);
        checkOutput("err_cnt", err_cnt, model_cnt);
        checkOutput("in_ready_in_done", in_ready, 0);
        last_exp = exp_data;
    endtask

    // Complete the DONE handshake and confirm return to IDLE
    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("hs_out_valid", out_valid, 0);
        checkOutput("hs_in_ready", in_ready, 1);
        checkOutput("hs_busy", busy, 0);
    endtask

    task automatic applyStimulus(input logic [N-1:0] word);
        startFrame(word);
        waitResult(word);
        handshake();
    endtask

    // Directed sequence with randomized words mixed in
    initial begin
        logic seen_valid;
        checks    = 0;
        failures  = 0;
        model_cnt = 0;
        mode      = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset values while rst is held low
        #2;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sh_in", sh_in, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", in_ready, 1);

        // Plain loopback, fixed word then random words
        applyStimulus(10'h2A5);
        for (int i = 0; i < 4; i++) applyStimulus(N'($urandom));

        // Stuck-at-0 return path
        mode = 1;
        applyStimulus(10'h3FF);
        checkOutput("stuck_cnt_one", err_cnt, 1);
        applyStimulus(10'h000);
        checkOutput("stuck_cnt_stays", err_cnt, 1);
        mode = 0;

        // Backpressure in DONE
        startFrame(N'($urandom));
        waitResult(dut.tx);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_data", out_data, last_exp);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        handshake();

        // Flush during SHIFT_OUT cycle 4 of a frame that would otherwise be an error
        mode = 1;
        startFrame(10'h3FF);
        repeat (N + 4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_sh_in", sh_in, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("flush_no_valid", seen_valid, 0);
        checkOutput("flush_err_cnt", err_cnt, model_cnt);
        mode = 0;

        // Flush together with in_valid in IDLE: word must be refused
        in_data  = 10'h1C3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_idle_busy", busy, 0);
        checkOutput("flush_idle_ready", in_ready, 1);

        // Flush together with the DONE handshake
        mode = 2;
        startFrame(10'h0F0);
        waitResult(10'h0F0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("flush_hs_valid", out_valid, 0);
        checkOutput("flush_hs_busy", busy, 0);
        checkOutput("flush_hs_cnt", err_cnt, model_cnt);
        mode = 0;

        // Asynchronous reset during SHIFT_IN cycle 3
        startFrame(N'($urandom));
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_in_ready", in_ready, 0);
        checkOutput("arst_sh_in", sh_in, 0);
        checkOutput("arst_out_data", out_data, 0);
        checkOutput("arst_err_cnt", err_cnt, 0);
        checkOutput("arst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("arst_ready_back", in_ready, 1);
        applyStimulus(10'h155);

        // Saturation with sh_out stuck at 1
        mode = 2;
        for (int i = 0; i < 17; i++) applyStimulus(10'h000);
        checkOutput("sat_final", err_cnt, SAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_loopback_ctrl.md
SHIFT_LOOPBACK_CTRL -- requirements
Module: shift_loopback_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the frame width in bits and the depth of the attached shift register.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the error-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous abort of the current frame.
REQ-006 The block SHALL have port in_data, input, N bits: the parallel word to transmit.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the controller can accept a word.
REQ-009 The block SHALL have port sh_in, output, 1 bit: serial data driven to the shift-register input.
REQ-010 The block SHALL have port sh_out, input, 1 bit: serial data returned from the shift-register output.
REQ-011 The block SHALL have port out_data, output, N bits: the received word.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data and err are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port err, output, 1 bit: the received word differs from the transmitted word.
REQ-015 The block SHALL have port err_cnt, output, CNT_W bits: the count of erroneous frames, saturating.
REQ-016 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, SHIFT_IN, SHIFT_OUT and DONE, with an internal bit counter of width clog2(N).
REQ-018 In IDLE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-019 On an edge where in_valid=1 and in_ready=1, the controller SHALL latch in_data into tx, clear the counter and enter SHIFT_IN.
REQ-020 In SHIFT_IN cycle c (c=0..N-1), sh_in SHALL equal tx[c], transmitting LSB first.
REQ-021 At the end of SHIFT_IN cycle N-1, the controller SHALL clear the counter and enter SHIFT_OUT.
REQ-022 In every state other than SHIFT_IN, sh_in SHALL be 0.
REQ-023 In SHIFT_OUT cycle c, the controller SHALL sample sh_out at the edge ending that cycle and store it into rx[c].
REQ-024 With an N-stage shift register attached, rx[c] SHALL equal tx[c].
REQ-025 After the sample for c=N-1, the controller SHALL enter DONE with out_data=rx, err=(rx!=tx) and out_valid=1.
REQ-026 out_valid SHALL first be 1 exactly 2N clock cycles after the accept edge.
REQ-027 In DONE, out_valid, out_data and err SHALL hold stable until out_valid=1 and out_ready=1 at an edge, after which the controller SHALL return to IDLE with out_valid=0.
REQ-028 err_cnt SHALL increment by 1 on entry to DONE when err=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-029 flush=1 at an edge in any state SHALL force IDLE, with out_valid=0, the counter cleared and err_cnt unchanged.
REQ-030 If flush=1 and a DONE handshake occur on the same edge, the handshake SHALL be taken and the next state SHALL be IDLE.
REQ-031 If flush=1 and in_valid=1 occur in IDLE on the same edge, the word SHALL NOT be accepted.
REQ-032 out_data and err SHALL retain their last values outside DONE; they are meaningful only while out_valid=1.

Reset
REQ-033 When rst=0, the block SHALL immediately (asynchronously) force state=IDLE, tx=0, rx=0, out_data=0, err=0, out_valid=0, sh_in=0, err_cnt=0, busy=0 and in_ready=0.
REQ-034 in_ready SHALL become 1 in the first cycle after rst returns high.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no out_valid pulse.

Verification
REQ-036 Loopback test: N=10 with a 10-stage shift register, accept 0x2A5 -> out_valid rises 20 cycles after accept, out_data=0x2A5, err=0, err_cnt=0.
REQ-037 Stuck-at test: sh_out tied to 0, send 0x3FF -> out_data=0x000, err=1, err_cnt=1; then send 0x000 -> err=0, err_cnt stays 1.
REQ-038 Backpressure test: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0; raise out_ready -> IDLE with in_ready=1 on the next cycle.
REQ-039 Flush test: assert flush at SHIFT_OUT cycle 4 -> IDLE on the next edge, no out_valid, err_cnt unchanged, sh_in=0.
REQ-040 Reset test: drop rst during SHIFT_IN cycle 3 -> all outputs reset without a clock edge; after release, in_ready=1 and a new frame 0x155 completes correctly.
REQ-041 Saturation test: CNT_W=4 with sh_out stuck at 1, send 17 frames of 0x000 -> err_cnt=15 after the 15th frame and remains 15.
